// File: rtl/fifo_rd_stream_adapter_pkg.sv
// fifo_stream_pkg: shared state type, default sizes and parity helper for fifo_rd_stream_adapter
package fifo_stream_pkg;
  typedef enum logic {STOP, RUN} rd_state_e;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_LEN  = 4;
  localparam int PARITY_MAX_W   = 256;
  // XOR reduce; callers zero-extend narrower words, which leaves the result unchanged
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// fifo_rd_stream_adapter_if: FIFO read port plus valid/ready burst stream; m_parity exists only with FIFO_RD_STREAM_PARITY_EN
interface fifo_rd_stream_adapter_if import fifo_stream_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
`ifdef FIFO_RD_STREAM_PARITY_EN
  logic                  m_parity;
  modport master (input fifo_empty, fifo_dout, m_ready, output fifo_rd_en, m_valid, m_data, m_last, m_parity);
  modport slave (output fifo_empty, fifo_dout, m_ready, input fifo_rd_en, m_valid, m_data, m_last, m_parity);
`else
  modport master (input fifo_empty, fifo_dout, m_ready, output fifo_rd_en, m_valid, m_data, m_last);
  modport slave (output fifo_empty, fifo_dout, m_ready, input fifo_rd_en, m_valid, m_data, m_last);
`endif
endinterface

// File: rtl/fifo_rd_stream_adapter_skid_buf2.sv
// stream_skid_buf2: 2-entry in-order buffer with a write port, a valid/ready read port and occupancy
module stream_skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   occ_o
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;
  assign valid_o = occ_q != 2'd0;
  assign pop     = valid_o & ready_i;
  assign data_o  = head_q;
  assign occ_o   = occ_q;
  // a pop shifts the tail forward; a write lands in the first slot left free after that pop
  always_comb begin
    head_d = pop ? ((wr_en_i && occ_q == 2'd1) ? wr_data_i : tail_q)
                 : ((wr_en_i && occ_q == 2'd0) ? wr_data_i : head_q);
    tail_d = (wr_en_i && ((occ_q == 2'd1 && !pop) || (occ_q == 2'd2 && pop))) ? wr_data_i : tail_q;
    occ_d  = occ_q + {1'b0, wr_en_i} - {1'b0, pop};
  end
  // storage and occupancy registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  // a write arriving while both entries are held means the upstream credit check was bypassed
  always_ff @(posedge clk)
    if (rst_n) assert (!(wr_en_i && occ_q == 2'd2));
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: drains a 1-cycle-latency FIFO into a burst-framed valid/ready stream; FIFO_RD_STREAM_PARITY_EN adds m_parity
module fifo_rd_stream_adapter import fifo_stream_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            run,
  output logic                            busy,
  fifo_rd_stream_adapter_if.master        bus
);
`ifdef FIFO_RD_STREAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int W  = DATA_WIDTH + PW;
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  rd_state_e     state_q;
  logic          inflight_q;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]    occ;
  logic [W-1:0]  wr_data, rd_data;
  logic          hs, credit_ok;
`ifdef FIFO_RD_STREAM_PARITY_EN
  assign wr_data      = {even_parity(PARITY_MAX_W'(bus.fifo_dout)), bus.fifo_dout};
  assign bus.m_parity = rd_data[DATA_WIDTH];
`else
  assign wr_data = bus.fifo_dout;
`endif
  assign bus.m_data = rd_data[DATA_WIDTH-1:0];
  assign hs         = bus.m_valid & bus.m_ready;
  // the slot freed by this cycle's handshake counts as credit, so a steady stream runs without bubbles
  assign credit_ok      = ({1'b0, occ} + {2'b0, inflight_q}) < (hs ? 3'd3 : 3'd2);
  // run gates reads combinationally so they stop in the very cycle run falls
  assign bus.fifo_rd_en = state_q == RUN && run && !bus.fifo_empty && credit_ok;
  assign bus.m_last     = bus.m_valid & (beat_cnt_q == LAST_BEAT);
  assign busy           = bus.m_valid | inflight_q;
  assign beat_cnt_d     = hs ? (beat_cnt_q == LAST_BEAT ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
  // run/stop FSM, read-latency tracker and burst beat counter; the counter survives STOP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= STOP;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= (state_q == STOP && run) ? RUN : (state_q == RUN && !run) ? STOP : state_q;
      inflight_q <= bus.fifo_rd_en;
      beat_cnt_q <= beat_cnt_d;
    end
  stream_skid_buf2 #(.W(W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (inflight_q),
    .wr_data_i (wr_data),
    .valid_o   (bus.m_valid),
    .ready_i   (bus.m_ready),
    .data_o    (rd_data),
    .occ_o     (occ)
  );
endmodule
